spi_slave_regif: RTL and testbench

//  Synthesizable SPI Mode 0 slave on the Zybo Z7-20. It receives CMD/ADDR/PAYLOAD frames from the ESP32 master.
//  It decodes them into writes and reads on a small register file, and exports register 0 as the LED brightness value.

---
 rtl/spi_slave_regif_pkg.sv | 23 ++
 rtl/spi_slave_regif_if.sv | 10 +
 rtl/spi_slave_regif_sync_edge.sv | 21 ++
 rtl/spi_slave_regif.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_regif_pkg.sv
// Shared constants and types for the SPI register-interface slave and its master mock.
package spi_slave_regif_pkg;
  localparam int CMD_BITS             = 8;
  localparam int ADDR_BITS            = 8;
  localparam int PAYLOAD_BITS         = 8;
  localparam int NUM_REGS             = 4;
  localparam int BRIGHTNESS_WIDTH     = 7;
  localparam int MASTER_FRAME_WIDTH   = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
  localparam int CLKS_PER_MASTER_SCLK = 5;

  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic       CS_ASSERT   = 1'b0;
  localparam logic       CS_DEASSERT = 1'b1;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DONE} state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/spi_slave_regif_if.sv
// SPI pin bundle between the master (ESP32 or mock) and the slave.
interface spi_slave_regif_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, output sclk, output mosi, input miso);
  modport slave  (input cs, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_slave_regif_sync_edge.sv
// Two-flop synchronizer for an async pin, with single-cycle rise/fall pulses on the synced level.
module spi_slave_regif_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  // [0],[1] form the synchronizer; [2] holds the previous synced level.
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], d_i};
  end

  assign lvl_o  = sh_q[1];
  assign rise_o =  sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] &  sh_q[2];
endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave decoding CMD/ADDR/PAYLOAD frames into register-file writes and reads.
module spi_slave_regif
  import spi_slave_regif_pkg::*;
#(
  parameter int CMD_W  = CMD_BITS,
  parameter int ADDR_W = ADDR_BITS,
  parameter int DATA_W = PAYLOAD_BITS,
  parameter int NREGS  = NUM_REGS,
  parameter int BRI_W  = BRIGHTNESS_WIDTH
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  spi_slave_regif_if.slave     spi,
  output logic [BRI_W-1:0]     brightness_o,
  output logic                 wr_strobe_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  output logic                 frame_err_o
);
  localparam int FW = max3(CMD_W, ADDR_W, DATA_W);
  localparam int CW = $clog2(FW) + 1;
  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W:0] NREGS_A = (ADDR_W+1)'(NREGS);

  // Pin sync: index 0 = cs, 1 = sclk, 2 = mosi.
  logic [2:0] pin, lvl, rise, fall;
  assign pin = {spi.mosi, spi.sclk, spi.cs};

  spi_slave_regif_sync_edge u_sync [2:0] (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .d_i    (pin),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
  assign cs_rise   = rise[0];
  assign cs_fall   = fall[0];
  assign sclk_rise = rise[1];
  assign sclk_fall = fall[1];
  assign mosi_s    = lvl[2];

  logic unused_sync;
  assign unused_sync = ^{lvl[1:0], rise[2], fall[2]};

  state_e                        state_q, state_d;
  logic [CW-1:0]                 bit_cnt_q;
  logic [FW-1:0]                 rx_q, rx_next;
  logic                          rd_q, tx_load_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [DATA_W-1:0]             tx_q;
  logic [NREGS-1:0][DATA_W-1:0]  regs_q;
  logic                          wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]             wr_addr_q;
  logic [DATA_W-1:0]             wr_data_q;
  logic [BRI_W-1:0]              bri_q;

  logic field_last, cmd_ok, addr_ok, in_frame;
  logic shift_en, frame_end, wr_en, err;

  assign rx_next  = {rx_q[FW-2:0], mosi_s};
  assign cmd_ok   = (rx_next[CMD_W-1:0] == CMD_W'(CMD_WRITE)) ||
                    (rx_next[CMD_W-1:0] == CMD_W'(CMD_READ));
  assign addr_ok  = ({1'b0, addr_q} < NREGS_A);
  assign in_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  always_comb begin
    field_last = 1'b0;
    case (state_q)
      ST_CMD:  field_last = (bit_cnt_q == CW'(CMD_W - 1));
      ST_ADDR: field_last = (bit_cnt_q == CW'(ADDR_W - 1));
      ST_DATA: field_last = (bit_cnt_q == CW'(DATA_W - 1));
      default: field_last = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. A final data rise wins over a simultaneous cs rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (cs_rise)                       state_d = ST_IDLE;
        else if (sclk_rise && field_last)  state_d = cmd_ok ? ST_ADDR : ST_DONE;
      end
      ST_ADDR: begin
        if (cs_rise)                       state_d = ST_IDLE;
        else if (sclk_rise && field_last)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sclk_rise && field_last)       state_d = cs_rise ? ST_IDLE : ST_DONE;
        else if (cs_rise)                  state_d = ST_IDLE;
      end
      ST_DONE: if (cs_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    shift_en  = sclk_rise && in_frame && !(cs_rise && state_q != ST_DATA);
    frame_end = (state_q == ST_DATA) && sclk_rise && field_last;
    wr_en     = frame_end && !rd_q && addr_ok;
    err       = (cs_rise && in_frame && !frame_end) ||
                ((state_q == ST_CMD) && !cs_rise && sclk_rise && field_last && !cmd_ok) ||
                (frame_end && !rd_q && !addr_ok);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      tx_load_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && cs_fall) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
        rd_q      <= 1'b0;
        tx_q      <= '0;
        tx_load_q <= 1'b0;
      end else if (shift_en) begin
        rx_q      <= rx_next;
        bit_cnt_q <= field_last ? '0 : bit_cnt_q + 1'b1;
        if (state_q == ST_CMD && field_last)
          rd_q <= (rx_next[CMD_W-1:0] == CMD_W'(CMD_READ));
        if (state_q == ST_ADDR && field_last) begin
          addr_q    <= rx_next[ADDR_W-1:0];
          tx_load_q <= rd_q;
        end
      end
      // First fall in DATA presents the read word's MSB; later falls shift.
      if (state_q == ST_DATA && sclk_fall) begin
        if (tx_load_q) begin
          tx_q      <= addr_ok ? regs_q[addr_q[RI-1:0]] : '0;
          tx_load_q <= 1'b0;
        end else begin
          tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      bri_q       <= '0;
    end else begin
      wr_strobe_q <= wr_en;
      frame_err_q <= err;
      bri_q       <= regs_q[0][BRI_W-1:0];
      if (wr_en) begin
        regs_q[addr_q[RI-1:0]] <= rx_next[DATA_W-1:0];
        wr_addr_q              <= addr_q;
        wr_data_q              <= rx_next[DATA_W-1:0];
      end
    end
  end

  assign spi.miso     = (state_q == ST_DATA && rd_q && spi.cs == CS_ASSERT) ? tx_q[DATA_W-1] : 1'b0;
  assign brightness_o = bri_q;
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_err_o  = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regif.sv
// Frame-level bench: mock SPI master, table of frames with expected effects, write scoreboard.
`timescale 1ns/1ps
module tb_spi_slave_regif;
  import spi_slave_regif_pkg::*;

  localparam int HALF = CLKS_PER_MASTER_SCLK;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [6:0] brightness;
  logic       wr_strobe, frame_err;
  logic [7:0] wr_addr, wr_data;

  always #4 sysclk = ~sysclk;

  spi_slave_regif_if bus ();

  spi_slave_regif dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .spi          (bus),
    .brightness_o (brightness),
    .wr_strobe_o  (wr_strobe),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .frame_err_o  (frame_err)
  );

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;

  typedef struct {
    string       name;
    logic [23:0] f;
    int          nbits;
    bit          exp_wr;
    int          exp_err;
    bit          chk_miso;
    logic [7:0]  exp_miso;
    logic [6:0]  exp_bri;
  } vec_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  err_pulses = 0;
  int  miso_hi    = 0;
  int  errors     = 0;
  int  checks     = 0;

  // Monitor: collect DUT-side events away from the active edge.
  always @(negedge sysclk) begin
    if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
    if (frame_err) err_pulses++;
    if (bus.miso)  miso_hi++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic cs_low();
    bus.cs = CS_ASSERT;
    clks(HALF);
  endtask

  task automatic cs_high();
    clks(HALF);
    bus.cs   = CS_DEASSERT;
    bus.mosi = 1'b0;
    clks(4 * HALF);
  endtask

  task automatic send_bits(input logic [23:0] f, input int from, input int upto,
                           output logic [7:0] rx);
    rx = '0;
    for (int i = from; i < upto; i++) begin
      bus.mosi = f[23-i];
      clks(HALF);
      bus.sclk = 1'b1;
      if (i >= 16) rx = {rx[6:0], bus.miso};
      clks(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rx;
    int e0, m0;
    wr_t o, e;
    if (v.exp_wr) exp_q.push_back({v.f[15:8], v.f[7:0]});
    e0 = err_pulses;
    m0 = miso_hi;
    cs_low();
    send_bits(v.f, 0, v.nbits, rx);
    cs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s write: got none expected %0h", v.name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s write: got %0h expected %0h", v.name, o, e);
        end
      end
    end
    chk({v.name, " extra writes"}, obs_q.size(), 0);
    obs_q.delete();
    chk({v.name, " frame_err"}, err_pulses - e0, v.exp_err);
    if (v.chk_miso) chk({v.name, " miso"}, rx, v.exp_miso);
    else            chk({v.name, " miso idle"}, miso_hi - m0, 0);
    chk({v.name, " brightness"}, brightness, v.exp_bri);
    chk({v.name, " miso after cs"}, bus.miso, 0);
  endtask

  vec_t vt[11];

  initial begin
    logic [7:0] rx;
    vt[0]  = '{"wr0",       24'h02_00_55, 24, 1'b1, 0, 1'b0, 8'h00, 7'h55};
    vt[1]  = '{"wr3",       24'h02_03_A5, 24, 1'b1, 0, 1'b0, 8'h00, 7'h55};
    vt[2]  = '{"rd3",       24'h03_03_00, 24, 1'b0, 0, 1'b1, 8'hA5, 7'h55};
    vt[3]  = '{"wr7 bad",   24'h02_07_11, 24, 1'b0, 1, 1'b0, 8'h00, 7'h55};
    vt[4]  = '{"rd3 again", 24'h03_03_00, 24, 1'b0, 0, 1'b1, 8'hA5, 7'h55};
    vt[5]  = '{"rd7 bad",   24'h03_07_00, 24, 1'b0, 0, 1'b1, 8'h00, 7'h55};
    vt[6]  = '{"cmd 7F",    24'h7F_00_00, 24, 1'b0, 1, 1'b0, 8'h00, 7'h55};
    vt[7]  = '{"trunc14",   24'h02_01_33, 14, 1'b0, 1, 1'b0, 8'h00, 7'h55};
    vt[8]  = '{"rd1 empty", 24'h03_01_00, 24, 1'b0, 0, 1'b1, 8'h00, 7'h55};
    vt[9]  = '{"wr1",       24'h02_01_33, 24, 1'b1, 0, 1'b0, 8'h00, 7'h55};
    vt[10] = '{"rd1",       24'h03_01_00, 24, 1'b0, 0, 1'b1, 8'h33, 7'h55};

    bus.cs = CS_DEASSERT; bus.sclk = 1'b0; bus.mosi = 1'b0;
    clks(3);
    chk("reset brightness", brightness, 0);
    chk("reset wr_strobe",  wr_strobe,  0);
    chk("reset wr_addr",    wr_addr,    0);
    chk("reset wr_data",    wr_data,    0);
    chk("reset frame_err",  frame_err,  0);
    chk("reset miso",       bus.miso,   0);
    rst_n = 1'b1;
    clks(10);

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Reset in the middle of the data field of a write.
    cs_low();
    send_bits(24'h02_00_22, 0, 19, rx);
    rst_n = 1'b0;
    #1;
    chk("midreset brightness", brightness, 0);
    chk("midreset wr_data",    wr_data,    0);
    chk("midreset wr_addr",    wr_addr,    0);
    chk("midreset miso",       bus.miso,   0);
    clks(3);
    rst_n = 1'b1;
    cs_high();
    obs_q.delete();
    chk("post-reset no write", wr_data, 0);
    run_vec('{"wr0 7F", 24'h02_00_7F, 24, 1'b1, 0, 1'b0, 8'h00, 7'h7F});
    run_vec('{"rd0 7F", 24'h03_00_00, 24, 1'b0, 0, 1'b1, 8'h7F, 7'h7F});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
